// File: rtl/montgomery_modexp_ctrl.sv
// -----------------------------------------------------------------------------
// montgomery_modexp_ctrl
//
// Modular-exponentiation sequencer for the Montgomery domain (N = 2^64-15,
// R = 2^64). It computes result_bar = base_bar^exp using left-to-right
// square-and-multiply. It drives one external montgomery_mul with at most one
// operation in flight.
//
// Optional build macro:
//   MODEXP_SKIP_LZ_EN - skip the leading zeros of exp on accept. acc starts at
//                       base_bar, and the scan starts just below the leading
//                       one. Results are unchanged; only latency differs.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   base_bar, exp   operands (base already in Montgomery form)
//   taken/ready_in  upstream operand handshake
//   result_bar      result in Montgomery form, valid while ready_out is high
//   ready_out/given downstream result handshake
//   mul_a_bar, mul_b_bar, mul_taken, mul_ready_in    multiplier issue port
//   mul_out_bar, mul_ready_out, mul_given            multiplier result port
// -----------------------------------------------------------------------------
module montgomery_modexp_ctrl #(
   parameter int          EXP_W     = 64,
   parameter logic [63:0] ONE_BAR   = 64'h0F,
   parameter int          FLUSH_CYC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      base_bar,
   input  logic [EXP_W-1:0] exp,
   input  logic             taken,
   output logic             ready_in,
   output logic [63:0]      result_bar,
   output logic             ready_out,
   input  logic             given,
   output logic [63:0]      mul_a_bar,
   output logic [63:0]      mul_b_bar,
   output logic             mul_taken,
   input  logic             mul_ready_in,
   input  logic [63:0]      mul_out_bar,
   input  logic             mul_ready_out,
   output logic             mul_given
);

   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [2:0] {
      FLUSH,
      IDLE,
      SQR_ISSUE,
      SQR_WAIT,
      MUL_ISSUE,
      MUL_WAIT,
      DONE
   } state_t;

   state_t           state;
   logic [63:0]      acc;
   logic [63:0]      base_r;
   logic [EXP_W-1:0] exp_r;
   logic [IDX_W-1:0] idx;
   logic [FC_W-1:0]  flush_cnt;
   logic [63:0]      op_a;
   logic [63:0]      op_b;

   logic             accept;
   state_t           ld_state;
   logic [63:0]      ld_acc;
   logic [IDX_W-1:0] ld_idx;

   // Handshakes are decoded from the registered state.
   assign ready_in   = (state == IDLE) || ((state == DONE) && given);
   assign accept     = ready_in && taken;
   assign ready_out  = (state == DONE);
   assign result_bar = acc;
   assign mul_a_bar  = op_a;
   assign mul_b_bar  = op_b;
   assign mul_taken  = ((state == SQR_ISSUE) || (state == MUL_ISSUE)) && mul_ready_in;
   // FLUSH pops whatever the un-reset multiplier still holds.
   assign mul_given  = ((state == FLUSH) || (state == SQR_WAIT) || (state == MUL_WAIT))
                       && mul_ready_out;

`ifdef MODEXP_SKIP_LZ_EN
   logic [IDX_W-1:0] lead_pos;

   // Index of the most significant set bit of exp (0 when exp is 0).
   always_comb begin
      lead_pos = '0;
      for (int unsigned i = 0; i < EXP_W; i++) begin
         if (exp[i]) lead_pos = IDX_W'(i);
      end
   end

   // The leading one's square-and-multiply collapses to acc = base.
   always_comb begin
      ld_state = SQR_ISSUE;
      ld_acc   = base_bar;
      ld_idx   = lead_pos - 1'b1;
      if (exp == '0) begin
         ld_state = DONE;
         ld_acc   = ONE_BAR;
         ld_idx   = '0;
      end else if (lead_pos == '0) begin
         ld_state = DONE;
         ld_idx   = '0;
      end
   end
`else
   always_comb begin
      ld_state = SQR_ISSUE;
      ld_acc   = ONE_BAR;
      ld_idx   = IDX_W'(EXP_W - 1);
   end
`endif

   // Operands are registered. They are loaded on the transition into an
   // ISSUE state from the value that acc takes on that same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FLUSH;
         acc       <= '0;
         base_r    <= '0;
         exp_r     <= '0;
         idx       <= '0;
         flush_cnt <= '0;
         op_a      <= '0;
         op_b      <= '0;
      end else if (accept) begin
         state  <= ld_state;
         acc    <= ld_acc;
         op_a   <= ld_acc;
         op_b   <= ld_acc;
         idx    <= ld_idx;
         base_r <= base_bar;
         exp_r  <= exp;
      end else begin
         unique case (state)
            FLUSH: begin
               if (flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
                  flush_cnt <= '0;
                  state     <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            IDLE: ;
            SQR_ISSUE: begin
               if (mul_ready_in) state <= SQR_WAIT;
            end
            MUL_ISSUE: begin
               if (mul_ready_in) state <= MUL_WAIT;
            end
            SQR_WAIT: begin
               if (mul_ready_out) begin
                  acc <= mul_out_bar;
                  if (exp_r[idx]) begin
                     state <= MUL_ISSUE;
                     op_a  <= mul_out_bar;
                     op_b  <= base_r;
                  end else if (idx != '0) begin
                     idx   <= idx - 1'b1;
                     state <= SQR_ISSUE;
                     op_a  <= mul_out_bar;
                     op_b  <= mul_out_bar;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            MUL_WAIT: begin
               if (mul_ready_out) begin
                  acc <= mul_out_bar;
                  if (idx != '0) begin
                     idx   <= idx - 1'b1;
                     state <= SQR_ISSUE;
                     op_a  <= mul_out_bar;
                     op_b  <= mul_out_bar;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (given) state <= IDLE;
            end
            default: state <= FLUSH;
         endcase
      end
   end

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_montgomery_modexp_ctrl
//
// Testbench for montgomery_modexp_ctrl. A behavioural Montgomery multiplier
// with latency 4 (REDC on 128-bit products) sits behind the DUT's multiplier
// ports. Expected results are computed in the normal domain (b^e mod N, then
// converted by multiplying by R mod N = 15) and queued on a scoreboard.
// Define MODEXP_SKIP_LZ_EN for both files to cover the leading-zero-skip build.
// -----------------------------------------------------------------------------
module tb_montgomery_modexp_ctrl;

   localparam int          EXP_W     = 64;
   localparam int          LAT       = 4;
   localparam int          FLUSH_CYC = 8;
   localparam logic [63:0] NMOD      = 64'hFFFF_FFFF_FFFF_FFF1;
   localparam logic [63:0] ONE_BAR   = 64'h0F;
   localparam int          BUDGET    = 2000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [63:0]      base_bar = '0;
   logic [EXP_W-1:0] exp = '0;
   logic             taken = 1'b0;
   logic             ready_in;
   logic [63:0]      result_bar;
   logic             ready_out;
   logic             given = 1'b0;
   logic [63:0]      mul_a_bar;
   logic [63:0]      mul_b_bar;
   logic             mul_taken;
   logic             mul_ready_in;
   logic [63:0]      mul_out_bar;
   logic             mul_ready_out;
   logic             mul_given;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int t0    = 0;

   logic [63:0] sb[$];

   montgomery_modexp_ctrl #(
      .EXP_W    (EXP_W),
      .ONE_BAR  (ONE_BAR),
      .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .base_bar     (base_bar),
      .exp          (exp),
      .taken        (taken),
      .ready_in     (ready_in),
      .result_bar   (result_bar),
      .ready_out    (ready_out),
      .given        (given),
      .mul_a_bar    (mul_a_bar),
      .mul_b_bar    (mul_b_bar),
      .mul_taken    (mul_taken),
      .mul_ready_in (mul_ready_in),
      .mul_out_bar  (mul_out_bar),
      .mul_ready_out(mul_ready_out),
      .mul_given    (mul_given)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference arithmetic ----------------
   function automatic logic [63:0] montmul(input logic [63:0] a, input logic [63:0] b);
      logic [63:0]  inv;
      logic [63:0]  nprime;
      logic [127:0] t;
      logic [63:0]  m;
      logic [129:0] u;
      inv = 64'd1;
      for (int i = 0; i < 6; i++) inv = inv * (64'd2 - NMOD * inv);
      nprime = -inv;
      t = {64'b0, a} * {64'b0, b};
      m = t[63:0] * nprime;
      u = {2'b0, t} + ({66'b0, m} * {66'b0, NMOD});
      u = u >> 64;
      if (u >= {66'b0, NMOD}) u = u - {66'b0, NMOD};
      return u[63:0];
   endfunction

   function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      p = ({64'b0, a} * {64'b0, b}) % {64'b0, NMOD};
      return p[63:0];
   endfunction

   // b^e mod N in the normal domain, returned in Montgomery form.
   function automatic logic [63:0] ref_bar(input logic [63:0] b, input logic [63:0] e);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 63; i >= 0; i--) begin
         r = mulmod(r, r);
         if (e[i]) r = mulmod(r, b);
      end
      return mulmod(r, 64'd15);
   endfunction

   function automatic int exp_ops(input logic [63:0] e);
`ifdef MODEXP_SKIP_LZ_EN
      int p;
      p = -1;
      for (int i = 0; i < 64; i++) if (e[i]) p = i;
      if (p < 0) return 0;
      return p + $countones(e) - 1;
`else
      return EXP_W + $countones(e);
`endif
   endfunction

   // ---------------- multiplier model ----------------
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   logic [63:0] m_res = '0;
   logic        stall_mul = 1'b0;
   logic        plant = 1'b0;
   logic [63:0] plant_val = '0;
   int          mul_ops = 0;
   int          dup_err = 0;
   int          given_err = 0;

   assign mul_ready_in  = !m_busy && !stall_mul;
   assign mul_ready_out = (m_busy && (m_cnt == 0)) || plant;
   assign mul_out_bar   = plant ? plant_val : m_res;

   always @(posedge clk) begin
      if (mul_taken) begin
         mul_ops <= mul_ops + 1;
         if (!mul_ready_in) dup_err <= dup_err + 1;
         m_busy <= 1'b1;
         m_cnt  <= LAT - 1;
         m_res  <= montmul(mul_a_bar, mul_b_bar);
      end else if (mul_given && mul_ready_out) begin
         m_busy <= 1'b0;
      end else if (m_busy && m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end
      if (mul_given && !mul_ready_out) given_err <= given_err + 1;
   end

   // ---------------- stimulus helpers (no checking) ----------------
   // Called at a negedge with ready_in high; returns at the negedge of cycle 1.
   task automatic launch(input logic [63:0] b, input logic [63:0] e, input logic [63:0] expv);
      base_bar = b;
      exp      = e;
      taken    = 1'b1;
      sb.push_back(expv);
      t0 = cyc;
      @(negedge clk);
      taken = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      while (!ready_out && (cyc - t0) < BUDGET) @(negedge clk);
      lat = ready_out ? (cyc - t0) : -1;
   endtask

   task automatic pop();
      given = 1'b1;
      @(negedge clk);
      given = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [195:0] outs;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      outs = {ready_in, ready_out, result_bar, mul_taken, mul_given, mul_a_bar, mul_b_bar};
      tests++;
      if (outs !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, want 0", outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= FLUSH_CYC; k++) begin
         @(negedge clk);
         tests++;
         if (ready_in !== (k == FLUSH_CYC)) begin
            fails++;
            $display("FAIL flush_ready_in cycle %0d: got %b, want %b", k, ready_in, k == FLUSH_CYC);
         end
         if (k == 3) begin
            plant_val = 64'hDEAD_BEEF_0BAD_F00D;
            plant = 1'b1;
            #1;
            tests++;
            if (mul_given !== 1'b1) begin
               fails++;
               $display("FAIL flush_drain: mul_given got %b, want 1", mul_given);
            end
         end else begin
            plant = 1'b0;
         end
      end
      tests++;
      if (result_bar !== 64'd0) begin
         fails++;
         $display("FAIL flush_acc_clean: result_bar got %h, want 0", result_bar);
      end
   endtask

   task automatic test_square();
      int lat, want_lat, ops0;
      logic [63:0] e;
`ifdef MODEXP_SKIP_LZ_EN
      want_lat = 6;
`else
      want_lat = 326;
`endif
      ops0 = mul_ops;
      launch(64'd45, 64'd2, ref_bar(64'd3, 64'd2));
      wait_done(lat);
      tests++;
      if (lat != want_lat) begin
         fails++;
         $display("FAIL square_latency: got %0d, want %0d", lat, want_lat);
      end
      tests++;
      if (mul_ops - ops0 != exp_ops(64'd2)) begin
         fails++;
         $display("FAIL square_ops: got %0d, want %0d", mul_ops - ops0, exp_ops(64'd2));
      end
      e = sb.pop_front();
      tests++;
      if (result_bar !== 64'd135 || e !== 64'd135) begin
         fails++;
         $display("FAIL square_result: got %0d, want 135 (model %0d)", result_bar, e);
      end
      pop();
   endtask

   task automatic test_pow5();
      int lat, ops0;
      logic [63:0] e;
      ops0 = mul_ops;
      launch(64'd30, 64'd5, ref_bar(64'd2, 64'd5));
      wait_done(lat);
      tests++;
      if (mul_ops - ops0 != exp_ops(64'd5)) begin
         fails++;
         $display("FAIL pow5_ops: got %0d, want %0d", mul_ops - ops0, exp_ops(64'd5));
      end
      tests++;
      if (lat != 1 + exp_ops(64'd5) * (LAT + 1)) begin
         fails++;
         $display("FAIL pow5_latency: got %0d, want %0d", lat, 1 + exp_ops(64'd5) * (LAT + 1));
      end
      e = sb.pop_front();
      tests++;
      if (result_bar !== e || e !== 64'd480) begin
         fails++;
         $display("FAIL pow5_result: got %0d, want 480 (model %0d)", result_bar, e);
      end
      pop();
   endtask

   task automatic test_exp_zero();
      int lat, want_lat;
      logic [63:0] e;
`ifdef MODEXP_SKIP_LZ_EN
      want_lat = 1;
`else
      want_lat = 321;
`endif
      launch(64'd12345, 64'd0, ONE_BAR);
      wait_done(lat);
      tests++;
      if (lat != want_lat) begin
         fails++;
         $display("FAIL exp0_latency: got %0d, want %0d", lat, want_lat);
      end
      e = sb.pop_front();
      tests++;
      if (result_bar !== e) begin
         fails++;
         $display("FAIL exp0_result: got %0d, want %0d", result_bar, e);
      end
      pop();
   endtask

   task automatic test_patterns();
      logic [63:0] etab[5];
      logic [63:0] b, e, r;
      int lat, ops0;
      etab[0] = 64'h1;
      etab[1] = 64'h8000_0000_0000_0001;
      etab[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      etab[3] = {$urandom, $urandom};
      etab[4] = 64'h0000_0000_0000_0003;
      for (int i = 0; i < 5; i++) begin
         b = 64'($urandom_range(1, 1000));
         ops0 = mul_ops;
         launch(mulmod(b, 64'd15), etab[i], ref_bar(b, etab[i]));
         wait_done(lat);
         tests++;
         if (lat != 1 + exp_ops(etab[i]) * (LAT + 1)) begin
            fails++;
            $display("FAIL pattern%0d_latency: got %0d, want %0d", i, lat,
                     1 + exp_ops(etab[i]) * (LAT + 1));
         end
         r = sb.pop_front();
         tests++;
         if (result_bar !== r || mul_ops - ops0 != exp_ops(etab[i])) begin
            fails++;
            $display("FAIL pattern%0d_result: got %h ops %0d, want %h ops %0d", i, result_bar,
                     mul_ops - ops0, r, exp_ops(etab[i]));
         end
         pop();
      end
   endtask

   task automatic test_backpressure();
      int lat, ops0, bad;
      logic [63:0] e;
      ops0 = mul_ops;
      stall_mul = 1'b1;
      launch(64'd30, 64'd5, ref_bar(64'd2, 64'd5));
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (mul_taken !== 1'b0) bad++;
         @(negedge clk);
      end
      stall_mul = 1'b0;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL stall_mul_taken: got %0d pushes while stalled, want 0", bad);
      end
      wait_done(lat);
      tests++;
      if (lat != 11 + exp_ops(64'd5) * (LAT + 1)) begin
         fails++;
         $display("FAIL stall_latency: got %0d, want %0d", lat, 11 + exp_ops(64'd5) * (LAT + 1));
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready_out !== 1'b1 || result_bar !== 64'd480) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL done_hold: got %0d unstable cycles, want 0", bad);
      end
      e = sb.pop_front();
      tests++;
      if (result_bar !== e) begin
         fails++;
         $display("FAIL stall_result: got %0d, want %0d", result_bar, e);
      end
      pop();
      tests++;
      if (dup_err != 0 || given_err != 0 || mul_ops - ops0 != exp_ops(64'd5)) begin
         fails++;
         $display("FAIL stall_protocol: dup %0d bad_pop %0d ops %0d, want 0 0 %0d",
                  dup_err, given_err, mul_ops - ops0, exp_ops(64'd5));
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [63:0] e;
      launch(64'd45, 64'd2, ref_bar(64'd3, 64'd2));
      wait_done(lat);
      given = 1'b1;
      #1;
      tests++;
      if (ready_in !== 1'b1) begin
         fails++;
         $display("FAIL b2b_ready_in: got %b, want 1", ready_in);
      end
      e = sb.pop_front();
      tests++;
      if (result_bar !== e) begin
         fails++;
         $display("FAIL b2b_first_result: got %0d, want %0d", result_bar, e);
      end
      launch(64'd30, 64'd5, ref_bar(64'd2, 64'd5));
      given = 1'b0;
      tests++;
      if (ready_out !== 1'b0 || mul_taken !== 1'b1 || mul_a_bar !== mul_b_bar) begin
         fails++;
         $display("FAIL b2b_no_bubble: ready_out %b mul_taken %b, want 0 1", ready_out, mul_taken);
      end
      wait_done(lat);
      tests++;
      if (lat != 1 + exp_ops(64'd5) * (LAT + 1)) begin
         fails++;
         $display("FAIL b2b_latency: got %0d, want %0d", lat, 1 + exp_ops(64'd5) * (LAT + 1));
      end
      e = sb.pop_front();
      tests++;
      if (result_bar !== e) begin
         fails++;
         $display("FAIL b2b_second_result: got %0d, want %0d", result_bar, e);
      end
      pop();
   endtask

   task automatic test_reset_mid();
      int n, lat;
      logic [63:0] e;
      launch(64'd30, 64'd5, ref_bar(64'd2, 64'd5));
      n = 0;
      while (!(mul_taken && mul_a_bar !== mul_b_bar) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= BUDGET) begin
         fails++;
         $display("FAIL midreset_find_mul: got timeout, want a multiply issue");
      end
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!ready_in && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (ready_in !== 1'b1 || m_busy !== 1'b0 || result_bar !== 64'd0) begin
         fails++;
         $display("FAIL midreset_flush: ready_in %b busy %b acc %h, want 1 0 0",
                  ready_in, m_busy, result_bar);
      end
      launch(64'd45, 64'd2, ref_bar(64'd3, 64'd2));
      wait_done(lat);
      e = sb.pop_front();
      tests++;
      if (result_bar !== 64'd135 || e !== 64'd135) begin
         fails++;
         $display("FAIL midreset_result: got %0d, want 135", result_bar);
      end
      pop();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_square();
      test_pow5();
      test_exp_zero();
      test_patterns();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
